// File: rtl/gestor_solicitudes_pkg.sv
// Shared definitions for the elevator request manager: request bit map,
// state-word fields, door states and the floor masks used to clear requests.
package gestor_solicitudes_pkg;

  localparam int N_S      = 10;
  localparam int S_F1_UP  = 0;
  localparam int S_F2_DN  = 1;
  localparam int S_F2_UP  = 2;
  localparam int S_F3_DN  = 3;
  localparam int S_F3_UP  = 4;
  localparam int S_F4_DN  = 5;
  localparam int S_CAB_F1 = 6;
  localparam int S_CAB_F2 = 7;
  localparam int S_CAB_F3 = 8;
  localparam int S_CAB_F4 = 9;

  localparam int E_MOV     = 3;
  localparam int E_DIR     = 2;
  localparam int E_PISO_HI = 1;
  localparam int E_PISO_LO = 0;

  typedef enum logic [1:0] {
    CERRADA  = 2'd0,
    ABIERTA  = 2'd1,
    CERRANDO = 2'd2
  } puerta_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Requests served when stopping at a floor while travelling in a direction.
  function automatic logic [N_S-1:0] clr_mask(input logic [1:0] piso, input logic subiendo);
    logic [N_S-1:0] m;
    case (piso)
      2'd0:    m = 10'h041;
      2'd1:    m = subiendo ? 10'h084 : 10'h082;
      2'd2:    m = subiendo ? 10'h110 : 10'h108;
      2'd3:    m = 10'h220;
      default: m = 10'h000;
    endcase
    return m;
  endfunction

  function automatic logic [N_S-1:0] piso_mask(input logic [1:0] piso);
    logic [N_S-1:0] m;
    case (piso)
      2'd0:    m = 10'h041;
      2'd1:    m = 10'h086;
      2'd2:    m = 10'h118;
      2'd3:    m = 10'h220;
      default: m = 10'h000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gestor_solicitudes_temporizador_puerta.sv
// Door state machine: open for T_PUERTA cycles, close over T_CIERRE cycles,
// reopen to a full open interval whenever reabrir pulses.
module temporizador_puerta
  import gestor_solicitudes_pkg::*;
#(
  parameter int T_PUERTA = 50,
  parameter int T_CIERRE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abrir,
  input  logic reabrir,
  output logic esperar
);

  localparam int CW = cnt_width(T_PUERTA, T_CIERRE);
  localparam logic [CW-1:0] CARGA_P = CW'(T_PUERTA - 1);
  localparam logic [CW-1:0] CARGA_C = CW'(T_CIERRE - 1);
  localparam logic [CW-1:0] UNO     = CW'(1);

  puerta_e       estado_q;
  logic [CW-1:0] cnt_q;
  logic          esperar_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= CERRADA;
      cnt_q     <= '0;
      esperar_q <= 1'b0;
    end else begin
      case (estado_q)
        CERRADA: begin
          if (abrir) begin
            estado_q  <= ABIERTA;
            cnt_q     <= CARGA_P;
            esperar_q <= 1'b1;
          end
        end
        ABIERTA: begin
          if (reabrir) begin
            cnt_q <= CARGA_P;
          end else if (cnt_q == '0) begin
            estado_q <= CERRANDO;
            cnt_q    <= CARGA_C;
          end else begin
            cnt_q <= cnt_q - UNO;
          end
        end
        CERRANDO: begin
          if (reabrir) begin
            estado_q <= ABIERTA;
            cnt_q    <= CARGA_P;
          end else if (cnt_q == '0) begin
            estado_q  <= CERRADA;
            esperar_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - UNO;
          end
        end
        default: begin
          estado_q  <= CERRADA;
          cnt_q     <= '0;
          esperar_q <= 1'b0;
        end
      endcase
    end
  end

  assign esperar = esperar_q;

endmodule

// File: rtl/gestor_solicitudes.sv
// Request register and door controller: latches button presses into s,
// clears the requests served on arrival and drives esperar via the door timer.
module gestor_solicitudes
  import gestor_solicitudes_pkg::*;
#(
  parameter int T_PUERTA = 50,
  parameter int T_CIERRE = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N_S-1:0] botones,
  input  logic [3:0]     estado,
  output logic [N_S-1:0] s,
  output logic           esperar
);

  logic [N_S-1:0] s_q, s_d;
  logic           mov_prev_q, mov_prev_d;
  logic [N_S-1:0] clr;
  logic [N_S-1:0] locales;
  logic [1:0]     piso;
  logic           llegada;
  logic           abrir;
  logic           reabrir;
  logic           esperar_s;

  always_comb begin
    piso       = estado[E_PISO_HI:E_PISO_LO];
    locales    = piso_mask(piso);
    llegada    = mov_prev_q & ~estado[E_MOV];
    clr        = '0;
    abrir      = 1'b0;
    reabrir    = 1'b0;
    if (!esperar_s) begin
      // Arrival has priority over a request for the floor we are idling at.
      if (llegada) begin
        abrir = 1'b1;
        clr   = clr_mask(piso, estado[E_DIR]);
      end else if (!estado[E_MOV] && ((s_q | botones) & locales) != '0) begin
        abrir = 1'b1;
        clr   = locales;
      end else begin
        clr = '0;
      end
    end else begin
      // Current-floor presses while open only extend the door, never latch.
      if ((botones & locales) != '0) begin
        reabrir = 1'b1;
        clr     = botones & locales;
      end else begin
        clr = '0;
      end
    end
    s_d        = (s_q | botones) & ~clr;
    mov_prev_d = estado[E_MOV];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q        <= '0;
      mov_prev_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      mov_prev_q <= mov_prev_d;
    end
  end

  temporizador_puerta #(
    .T_PUERTA (T_PUERTA),
    .T_CIERRE (T_CIERRE)
  ) u_puerta (
    .clk     (clk),
    .rst_n   (rst_n),
    .abrir   (abrir),
    .reabrir (reabrir),
    .esperar (esperar_s)
  );

  assign s       = s_q;
  assign esperar = esperar_s;

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Scoreboard bench: stimulus pushes expected {s, esperar} from a behavioural
// model; a monitor pops and compares one entry after every clock edge.
module tb_gestor_solicitudes;

  localparam int TP = 50;
  localparam int TC = 10;

  logic       clk;
  logic       rst_n;
  logic [9:0] botones;
  logic [3:0] estado;
  logic [9:0] s;
  logic       esperar;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  // Model state: latched requests, door cycles still to stay not-closed.
  logic [9:0] m_s;
  int         m_open;
  logic       m_prev;

  gestor_solicitudes #(.T_PUERTA(TP), .T_CIERRE(TC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .botones (botones),
    .estado  (estado),
    .s       (s),
    .esperar (esperar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [9:0] b, input logic [3:0] e);
    int         f;
    logic [9:0] pisobits;
    logic [9:0] servido;
    logic [9:0] borrar;
    bit         arr;
    if (!r) begin
      m_s    = 10'h000;
      m_open = 0;
      m_prev = 1'b0;
    end else begin
      f        = int'(e[1:0]);
      pisobits = 10'h000;
      pisobits[6 + f] = 1'b1;
      if (f > 0) pisobits[2 * f - 1] = 1'b1;
      if (f < 3) pisobits[2 * f] = 1'b1;
      servido = 10'h000;
      servido[6 + f] = 1'b1;
      if (f == 0)      servido[0] = 1'b1;
      else if (f == 3) servido[5] = 1'b1;
      else if (e[2])   servido[2 * f] = 1'b1;
      else             servido[2 * f - 1] = 1'b1;
      arr    = m_prev && !e[3];
      borrar = 10'h000;
      if (m_open == 0) begin
        if (arr) begin
          borrar = servido;
          m_open = TP + TC;
        end else if (!e[3] && ((m_s | b) & pisobits) != 10'h000) begin
          borrar = pisobits;
          m_open = TP + TC;
        end
      end else if ((b & pisobits) != 10'h000) begin
        borrar = b & pisobits;
        m_open = TP + TC;
      end else begin
        m_open = m_open - 1;
      end
      m_s    = (m_s | b) & ~borrar;
      m_prev = e[3];
    end
    exp_q.push_back({m_s, (m_open > 0)});
  endtask

  task automatic step(input logic r, input logic [9:0] b, input logic [3:0] e);
    @(negedge clk);
    rst_n   = r;
    botones = b;
    estado  = e;
    model_step(r, b, e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("s", {22'd0, s}, {22'd0, e[10:1]});
        chk("esperar", {31'd0, esperar}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    logic [9:0] b;
    logic [3:0] est;
    logic       r;
    int         guard;
    rst_n   = 1'b0;
    botones = 10'h000;
    estado  = 4'b1000;

    // Reset drops latched requests.
    step(1'b0, 10'h000, 4'b1000);
    step(1'b0, 10'h000, 4'b1000);
    step(1'b1, 10'h088, 4'b1000);
    step(1'b1, 10'h000, 4'b1000);
    step(1'b0, 10'h000, 4'b1000);
    after_edge();
    chk("reset_s", {22'd0, s}, 32'h0);
    chk("reset_esperar", {31'd0, esperar}, 32'h0);
    step(1'b1, 10'h000, 4'b1000);

    // Arrival going up at F3 serves bits 4 and 8, keeps bit 3.
    step(1'b1, 10'h118, 4'b1110);
    step(1'b1, 10'h000, 4'b1110);
    step(1'b1, 10'h000, 4'b0110);
    after_edge();
    chk("arrival_s", {22'd0, s}, 32'h008);
    chk("arrival_esperar", {31'd0, esperar}, 32'h1);
    for (int i = 0; i < 70; i++) step(1'b1, 10'h000, 4'b0110);

    // Idle local request is never latched.
    step(1'b0, 10'h000, 4'b0001);
    step(1'b1, 10'h002, 4'b0001);
    after_edge();
    chk("local_s1", {31'd0, s[1]}, 32'h0);
    chk("local_esperar", {31'd0, esperar}, 32'h1);
    for (int i = 0; i < 62; i++) step(1'b1, 10'h000, 4'b0001);

    // Reopen during the closing phase at F1.
    step(1'b0, 10'h000, 4'b0000);
    step(1'b1, 10'h001, 4'b0000);
    for (int i = 0; i < 54; i++) step(1'b1, 10'h000, 4'b0000);
    step(1'b1, 10'h040, 4'b0000);
    after_edge();
    chk("reopen_s6", {31'd0, s[6]}, 32'h0);
    for (int i = 0; i < 59; i++) step(1'b1, 10'h000, 4'b0000);
    after_edge();
    chk("reopen_still_open", {31'd0, esperar}, 32'h1);
    step(1'b1, 10'h000, 4'b0000);
    after_edge();
    chk("reopen_closed", {31'd0, esperar}, 32'h0);

    // Collision at F2 going down, plus another-floor press.
    step(1'b0, 10'h000, 4'b1001);
    step(1'b1, 10'h000, 4'b1001);
    step(1'b1, 10'h202, 4'b0001);
    after_edge();
    chk("collision_s1", {31'd0, s[1]}, 32'h0);
    chk("collision_s9", {31'd0, s[9]}, 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 10'h000, 4'b0001);

    // Randomized traffic.
    est = 4'b1000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) est = 4'($urandom);
      b = 10'h000;
      for (int k = 0; k < 10; k++) if ($urandom_range(0, 15) == 0) b[k] = 1'b1;
      r = ($urandom_range(0, 299) != 0);
      step(r, b, est);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
